vram_writer: RTL and testbench
==============================

// Module: vram_writer
//
// PURPOSE
// Upstream stage of the display block: sole driver of its VRAM write bus (addr, din, we, color).
// Registers CPU writes and holds the MX colour register written through an I/O port.
// Adds a hardware screen-fill engine that writes the whole VRAM window (0x9000-0xBFFF)
// with a fill byte and fill colour, for OSD "clear screen" and cold boot.
// CPU writes always win arbitration; the fill engine only uses free cycles.
//
// PARAMETERS
// FILL_START   16'h9000  first fill address (inclusive)
// FILL_END     16'hBFFF  last fill address (inclusive)
// COLOR_PORT   16'hFFF8  CPU address that writes the colour register
// COLOR_RESET  8'h70     colour register reset value (fg=0111, bg=0000)
// FILL_GAP     0         idle slots inserted after each fill write (0 = back-to-back)
//
// PORTS
// clk_sys     in   1   system clock
// reset_n     in   1   synchronous reset, active low
// cpu_addr    in   16  CPU address
// cpu_dout    in   8   CPU write data
// cpu_wr      in   1   CPU write strobe, one clk_sys cycle per write
// fill_start  in   1   start-fill pulse
// fill_data   in   8   fill byte (bitmap)
// fill_color  in   8   fill colour byte
// addr        out  16  VRAM bus address
// din         out  8   VRAM bus data
// we          out  1   VRAM bus write enable, one-cycle pulse per write
// color       out  8   colour byte accompanying the write
// color_reg   out  8   current colour register value
// fill_busy   out  1   fill engine active
// fill_done   out  1   one-cycle pulse with the last fill write
//
// BEHAVIOUR
// - All outputs are registered.
// - Reset (reset_n=0 at an edge) sets: addr=0, din=0, we=0, color=COLOR_RESET,
//   color_reg=COLOR_RESET, fill_busy=0, fill_done=0, state=IDLE, ptr=FILL_START, gap=0.
//   Reset in the middle of a fill aborts it; no further fill writes are issued.
// - CPU path, latency 1. When cpu_wr=1 at edge k:
//   - cpu_addr==COLOR_PORT: color_reg<=cpu_dout at edge k; we stays 0, so the
//     write is not forwarded to VRAM.
//   - any other address: after edge k, we=1, addr=cpu_addr, din=cpu_dout and
//     color=color_reg, using the value held before edge k. Every address is forwarded;
//     the display block decodes the window itself.
// - addr/din/color hold their last values while we=0.
// - States:
//   - IDLE: fill_start=1 -> FILL, ptr=FILL_START, gap=0, fill_busy=1 after the same edge.
//     fill_start while in FILL is ignored.
//   - FILL: an edge is a fill slot when cpu_wr=0 and gap=0. In a slot the edge registers
//     we=1, addr=ptr, din=fill_data, color=fill_color, sets ptr<=ptr+1 and gap<=FILL_GAP.
//     Outside a slot: if gap!=0, gap decrements; the CPU write proceeds and ptr holds.
//     A slot preempted by the CPU is retried at the next free edge.
//   - The slot with ptr==FILL_END also registers fill_done=1 and fill_busy=0 and returns
//     to IDLE. fill_done is high in the same cycle as the last fill we.
// - fill_data and fill_color are sampled at each slot, not latched at start.
// - The fill never touches color_reg.
// - Fill writes FILL_END-FILL_START+1 bytes (12288 at defaults).
// - ptr is 16 bits and never wraps: FILL_END is the terminal compare.
//
// TESTING
// - Reset, then CPU wr 0x9000/0x55 -> next cycle we=1, addr=9000, din=55, color=70; then we=0.
// - CPU wr COLOR_PORT/0x4A then wr 0xA123/0xFF -> no we for port write; second gives color=4A.
// - fill_start, fill_data=00, fill_color=07, no CPU traffic -> 12288 consecutive we,
//   addr 9000..BFFF; fill_done with addr=BFFF; fill_busy low afterwards.
// - CPU wr 0x8000 mid-fill at ptr=0x9100 -> that cycle addr=8000; next fill write is 9100,
//   no address skipped or duplicated; total fill writes still 12288.
// - FILL_GAP=2 -> fill we every 3rd cycle.
// - reset_n=0 mid-fill -> fill_busy=0, no fill_done, no further we.
// - Then fill_start -> restarts at 9000.

Source files
------------

// File: rtl/vram_writer.sv
// ----------------------------------------------------------------------------
// vram_writer : sole VRAM write-bus driver; registers CPU writes, holds the
//               colour register and runs a free-cycle screen-fill engine.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vram_writer #(
  parameter logic [15:0] FILL_START  = 16'h9000,
  parameter logic [15:0] FILL_END    = 16'hBFFF,
  parameter logic [15:0] COLOR_PORT  = 16'hFFF8,
  parameter logic [7:0]  COLOR_RESET = 8'h70,
  parameter int          FILL_GAP    = 0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  input  logic        fill_start,
  input  logic [7:0]  fill_data,
  input  logic [7:0]  fill_color,
  output logic [15:0] addr,
  output logic [7:0]  din,
  output logic        we,
  output logic [7:0]  color,
  output logic [7:0]  color_reg,
  output logic        fill_busy,
  output logic        fill_done
);

  localparam int GAP_W = (FILL_GAP > 0) ? $clog2(FILL_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(FILL_GAP);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [15:0]      ptr_q, ptr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       din_q, din_d;
  logic             we_q, we_d;
  logic [7:0]       color_q, color_d;
  logic [7:0]       color_reg_q, color_reg_d;
  logic             fill_busy_q, fill_busy_d;
  logic             fill_done_q, fill_done_d;

  logic slot;
  logic last_slot;
  logic color_wr;

  // The CPU owns every edge it writes on; the fill only gets the leftovers.
  assign slot      = (state_q == FILL) && !cpu_wr && (gap_q == '0);
  assign last_slot = slot && (ptr_q == FILL_END);
  assign color_wr  = cpu_wr && (cpu_addr == COLOR_PORT);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= FILL_START;
      gap_q       <= '0;
      addr_q      <= 16'h0000;
      din_q       <= 8'h00;
      we_q        <= 1'b0;
      color_q     <= COLOR_RESET;
      color_reg_q <= COLOR_RESET;
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gap_q       <= gap_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      color_q     <= color_d;
      color_reg_q <= color_reg_d;
      fill_busy_q <= fill_busy_d;
      fill_done_q <= fill_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_start) state_d = FILL;
      FILL:    if (last_slot)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    gap_d       = gap_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = 1'b0;
    color_d     = color_q;
    color_reg_d = color_reg_q;
    fill_busy_d = fill_busy_q;
    fill_done_d = 1'b0;

    if (color_wr) begin
      color_reg_d = cpu_dout;
    end else if (cpu_wr) begin
      we_d    = 1'b1;
      addr_d  = cpu_addr;
      din_d   = cpu_dout;
      color_d = color_reg_q;
    end

    case (state_q)
      IDLE: begin
        if (fill_start) begin
          ptr_d       = FILL_START;
          gap_d       = '0;
          fill_busy_d = 1'b1;
        end
      end
      FILL: begin
        if (slot) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          din_d   = fill_data;
          color_d = fill_color;
          ptr_d   = ptr_q + 16'd1;
          gap_d   = GAP_RELOAD;
          if (last_slot) begin
            fill_done_d = 1'b1;
            fill_busy_d = 1'b0;
          end
        end else if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        fill_busy_d = 1'b0;
      end
    endcase
  end

  assign addr      = addr_q;
  assign din       = din_q;
  assign we        = we_q;
  assign color     = color_q;
  assign color_reg = color_reg_q;
  assign fill_busy = fill_busy_q;
  assign fill_done = fill_done_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_writer.sv
// ----------------------------------------------------------------------------
// tb_vram_writer : directed vectors and fill sequences for vram_writer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vram_writer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic        fill_start;
  logic [7:0]  fill_data;
  logic [7:0]  fill_color;

  logic [15:0] addr,  g_addr;
  logic [7:0]  din,   g_din;
  logic        we,    g_we;
  logic [7:0]  color, g_color;
  logic [7:0]  color_reg, g_color_reg;
  logic        fill_busy, g_fill_busy;
  logic        fill_done, g_fill_done;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  vram_writer dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .fill_start(fill_start), .fill_data(fill_data), .fill_color(fill_color),
    .addr(addr), .din(din), .we(we), .color(color),
    .color_reg(color_reg), .fill_busy(fill_busy), .fill_done(fill_done)
  );

  vram_writer #(.FILL_GAP(2)) dut_gap (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr),
    .fill_start(fill_start), .fill_data(fill_data), .fill_color(fill_color),
    .addr(g_addr), .din(g_din), .we(g_we), .color(g_color),
    .color_reg(g_color_reg), .fill_busy(g_fill_busy), .fill_done(g_fill_done)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        wr;
    logic        e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_din;
    logic [7:0]  e_color;
    logic [7:0]  e_creg;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one complete fill on the gap-0 instance against a cycle model.
  task automatic run_fill(input bit with_cpu, input logic [7:0] creg_in, output logic [7:0] creg_out);
    logic [15:0] exp_ptr;
    logic [7:0]  creg, cd, fd, fc;
    logic [15:0] ca;
    bit          cw, e1, e2;
    int          fills, bad, cyc, burst;
    creg = creg_in;
    fill_data = 8'h00; fill_color = 8'h07; fill_start = 1'b1; cpu_wr = 1'b0;
    tick();
    chk("start_busy", fill_busy, 1);
    chk("start_no_we", we, 0);
    fill_start = 1'b0;
    exp_ptr = 16'h9000; fills = 0; bad = 0; cyc = 0; e1 = 0; e2 = 0; burst = 0;
    while (exp_ptr <= 16'hBFFF && exp_ptr >= 16'h9000 && cyc < 13000) begin
      cw = 0; ca = 16'h0; cd = 8'h0;
      if (with_cpu) begin
        if (!e1 && exp_ptr == 16'h9100) begin
          cw = 1; ca = 16'h8000; cd = 8'h5A; e1 = 1;
        end else if (!e2 && exp_ptr == 16'h9200) begin
          cw = 1; ca = 16'hFFF8; cd = 8'h33; e2 = 1;
        end else if (burst < 2 && exp_ptr == 16'hA000) begin
          cw = 1; ca = 16'h1111 + 16'(burst); cd = 8'(burst + 1); burst++;
        end
      end
      fd = cyc[7:0];
      fc = (cyc < 6000) ? 8'h07 : 8'h16;
      fill_start = (cyc == 50);
      cpu_wr = cw; cpu_addr = ca; cpu_dout = cd; fill_data = fd; fill_color = fc;
      tick();
      if (cw && ca == 16'hFFF8) begin
        if (we !== 1'b0 || fill_done !== 1'b0 || fill_busy !== 1'b1) bad++;
        creg = cd;
      end else if (cw) begin
        if (we !== 1'b1 || addr !== ca || din !== cd || color !== creg ||
            fill_done !== 1'b0 || fill_busy !== 1'b1) bad++;
      end else begin
        if (we !== 1'b1 || addr !== exp_ptr || din !== fd || color !== fc ||
            fill_done !== (exp_ptr == 16'hBFFF) || fill_busy !== (exp_ptr != 16'hBFFF)) bad++;
        exp_ptr = exp_ptr + 16'd1;
        fills++;
      end
      cyc++;
    end
    cpu_wr = 1'b0; fill_start = 1'b0;
    chk("fill_write_count", fills, 12288);
    chk("fill_seq_mismatches", bad, 0);
    tick();
    chk("post_fill_we", we, 0);
    chk("post_fill_busy", fill_busy, 0);
    chk("post_fill_done", fill_done, 0);
    chk("post_fill_addr_hold", addr, 16'hBFFF);
    chk("post_fill_color_reg", color_reg, creg);
    creg_out = creg;
  endtask

  initial begin
    logic [7:0] creg;
    int bad;

    vecs[0] = '{16'h9000, 8'h55, 1'b1, 1'b1, 16'h9000, 8'h55, 8'h70, 8'h70};
    vecs[1] = '{16'h0000, 8'h00, 1'b0, 1'b0, 16'h9000, 8'h55, 8'h70, 8'h70};
    vecs[2] = '{16'hFFF8, 8'h4A, 1'b1, 1'b0, 16'h9000, 8'h55, 8'h70, 8'h4A};
    vecs[3] = '{16'hA123, 8'hFF, 1'b1, 1'b1, 16'hA123, 8'hFF, 8'h4A, 8'h4A};
    vecs[4] = '{16'hA124, 8'h01, 1'b1, 1'b1, 16'hA124, 8'h01, 8'h4A, 8'h4A};
    vecs[5] = '{16'hFFF8, 8'h12, 1'b1, 1'b0, 16'hA124, 8'h01, 8'h4A, 8'h12};
    vecs[6] = '{16'h0000, 8'hAB, 1'b1, 1'b1, 16'h0000, 8'hAB, 8'h12, 8'h12};
    vecs[7] = '{16'h5555, 8'h99, 1'b0, 1'b0, 16'h0000, 8'hAB, 8'h12, 8'h12};

    reset_n = 1'b0; cpu_addr = 16'h0; cpu_dout = 8'h0; cpu_wr = 1'b0;
    fill_start = 1'b0; fill_data = 8'h0; fill_color = 8'h0;
    repeat (3) tick();
    chk("rst_addr", addr, 16'h0000);
    chk("rst_din", din, 8'h00);
    chk("rst_we", we, 0);
    chk("rst_color", color, 8'h70);
    chk("rst_color_reg", color_reg, 8'h70);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      cpu_addr = vecs[i].a; cpu_dout = vecs[i].d; cpu_wr = vecs[i].wr;
      tick();
      chk($sformatf("vec%0d_we", i), we, vecs[i].e_we);
      chk($sformatf("vec%0d_addr", i), addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_din", i), din, vecs[i].e_din);
      chk($sformatf("vec%0d_color", i), color, vecs[i].e_color);
      chk($sformatf("vec%0d_color_reg", i), color_reg, vecs[i].e_creg);
      chk($sformatf("vec%0d_busy", i), fill_busy, 0);
    end
    cpu_wr = 1'b0;

    run_fill(1'b0, 8'h12, creg);
    run_fill(1'b1, creg, creg);
    chk("color_reg_after_cpu_fill", color_reg, 8'h33);

    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("gap_start_busy", g_fill_busy, 1);
    bad = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (g_we !== ((j % 3) == 0)) bad++;
      if ((j % 3) == 0 && g_addr !== 16'h9000 + 16'(j / 3)) bad++;
    end
    chk("gap_pattern_mismatches", bad, 0);

    reset_n = 1'b0;
    tick();
    chk("midrst_busy", fill_busy, 0);
    chk("midrst_we", we, 0);
    chk("midrst_done", fill_done, 0);
    chk("midrst_color_reg", color_reg, 8'h70);
    chk("midrst_gap_busy", g_fill_busy, 0);
    reset_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (we !== 1'b0 || fill_done !== 1'b0 || fill_busy !== 1'b0 || g_we !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    fill_data = 8'hAB; fill_color = 8'h07; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    chk("restart_busy", fill_busy, 1);
    tick();
    chk("restart_we", we, 1);
    chk("restart_addr", addr, 16'h9000);
    chk("restart_din", din, 8'hAB);
    chk("restart_gap_addr", g_addr, 16'h9000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
